cpu_id_hz: RTL

Parametrised next-generation instruction-decode stage for the 5-stage PLP core. Adds three things to the basic decoder:
- Register-file write-through bypass.
- MEM-stage operand forwarding into branch/jump-register resolution.
- Load-use and branch-use hazard interlock with stall/flush handshake to IF.

Sits between cpu_if and cpu_ex. It drives the ID/EX pipeline register, and its branch/jump outputs feed the IF PC mux.

---
 rtl/cpu_id_hz.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/cpu_id_hz.sv
//==============================================================================
// cpu_id_hz : PLP instruction-decode stage with regfile bypass, MEM forwarding
// and load-use / branch-use interlock.                     Rev 1.0
//==============================================================================
`default_nettype none

module cpu_id_hz #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int JAL_LINK = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [XLEN-1:0] if_pc,
  input  logic [31:0]     if_inst,
  input  logic            if_valid,
  input  logic            flush,
  input  logic            wb_rfw,
  input  logic [4:0]      wb_rf_waddr,
  input  logic [XLEN-1:0] wb_rf_wdata,
  input  logic            mem_rfw,
  input  logic [4:0]      mem_rf_waddr,
  input  logic            mem_is_load,
  input  logic [XLEN-1:0] mem_alu_result,
  output logic            stall,
  output logic            c_b,
  output logic            c_j,
  output logic [XLEN-1:0] baddr,
  output logic [XLEN-1:0] jaddr,
  output logic            p_valid,
  output logic [XLEN-1:0] p_rfa,
  output logic [XLEN-1:0] p_rfb,
  output logic [XLEN-1:0] p_rfbse,
  output logic [4:0]      p_shamt,
  output logic [5:0]      p_func,
  output logic [4:0]      p_rf_waddr,
  output logic [XLEN-1:0] p_jalra,
  output logic            p_c_rfw,
  output logic            p_c_drw,
  output logic [1:0]      p_c_wbsource,
  output logic [5:0]      p_c_alucontrol
);

  localparam int AW = $clog2(NREG);

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ANDI  = 6'h0c;
  localparam logic [5:0] OP_ORI   = 6'h0d;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2b;
  localparam logic [5:0] FN_JR    = 6'h08;
  localparam logic [5:0] FN_JALR  = 6'h09;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] rfa;
    logic [XLEN-1:0] rfb;
    logic [XLEN-1:0] rfbse;
    logic [4:0]      shamt;
    logic [5:0]      func;
    logic [4:0]      waddr;
    logic [XLEN-1:0] jalra;
    logic            rfw;
    logic            drw;
    logic [1:0]      wbs;
    logic [5:0]      alu;
  } idex_t;

  idex_t           idex_q, idex_d;
  logic [XLEN-1:0] rf_q [NREG];

  logic [5:0]      op, fn;
  logic [4:0]      rs, rt, rd;
  logic [15:0]     imm;
  logic            is_r, is_j, is_jal, is_beq, is_bne, is_lw, is_sw, is_jr, is_jalr, is_bru;
  logic            uses_rs, uses_rt;
  logic [XLEN-1:0] rs_rf, rt_rf, rs_val, rt_val, imm_ext, pc4;
  logic            ex_hit, mem_hit, ld_use, br_ex, br_mem, go;

  assign op  = if_inst[31:26];
  assign rs  = if_inst[25:21];
  assign rt  = if_inst[20:16];
  assign rd  = if_inst[15:11];
  assign fn  = if_inst[5:0];
  assign imm = if_inst[15:0];

  assign is_r    = (op == OP_RTYPE);
  assign is_j    = (op == OP_J);
  assign is_jal  = (op == OP_JAL);
  assign is_beq  = (op == OP_BEQ);
  assign is_bne  = (op == OP_BNE);
  assign is_lw   = (op == OP_LW);
  assign is_sw   = (op == OP_SW);
  assign is_jr   = is_r && (fn == FN_JR);
  assign is_jalr = is_r && (fn == FN_JALR);
  assign is_bru  = is_beq || is_bne || is_jr || is_jalr;

  assign uses_rs = if_valid && !(is_j || is_jal);
  assign uses_rt = if_valid && (is_r || is_beq || is_bne || is_sw);

  always_ff @(posedge clk) begin
    if (wb_rfw && (wb_rf_waddr != 5'd0))
      rf_q[wb_rf_waddr[AW-1:0]] <= wb_rf_wdata;
  end

  // Write-through read: a same-cycle writeback wins over the stored value.
  assign rs_rf = (rs[AW-1:0] == '0) ? '0 :
                 (wb_rfw && (wb_rf_waddr[AW-1:0] == rs[AW-1:0])) ? wb_rf_wdata : rf_q[rs[AW-1:0]];
  assign rt_rf = (rt[AW-1:0] == '0) ? '0 :
                 (wb_rfw && (wb_rf_waddr[AW-1:0] == rt[AW-1:0])) ? wb_rf_wdata : rf_q[rt[AW-1:0]];

  // Load results are not yet available in MEM, so they never forward.
  assign rs_val = (mem_rfw && !mem_is_load && (mem_rf_waddr == rs) && (rs != 5'd0)) ? mem_alu_result : rs_rf;
  assign rt_val = (mem_rfw && !mem_is_load && (mem_rf_waddr == rt) && (rt != 5'd0)) ? mem_alu_result : rt_rf;

  assign imm_ext = (op == OP_ANDI || op == OP_ORI) ? {{(XLEN-16){1'b0}}, imm}
                                                   : {{(XLEN-16){imm[15]}}, imm};
  assign pc4     = if_pc + XLEN'(4);

  assign ex_hit  = (uses_rs && (rs == idex_q.waddr)) || (uses_rt && (rt == idex_q.waddr));
  assign mem_hit = (uses_rs && (rs == mem_rf_waddr)) || (uses_rt && (rt == mem_rf_waddr));
  assign ld_use  = idex_q.valid && (idex_q.wbs == 2'd1) && (idex_q.waddr != 5'd0) && ex_hit;
  assign br_ex   = is_bru && idex_q.valid && idex_q.rfw && (idex_q.waddr != 5'd0) && ex_hit;
  assign br_mem  = is_bru && mem_is_load && mem_rfw && mem_hit;

  assign stall = if_valid && !flush && (ld_use || br_ex || br_mem);
  assign go    = if_valid && !flush && !stall;

  assign c_b   = go && ((is_beq && (rs_val == rt_val)) || (is_bne && (rs_val != rt_val)));
  assign c_j   = go && (is_j || is_jal || is_jr || is_jalr);
  assign baddr = pc4 + {{(XLEN-18){imm[15]}}, imm, 2'b00};
  assign jaddr = (is_jr || is_jalr) ? rs_val : {pc4[XLEN-1:28], if_inst[25:0], 2'b00};

  always_comb begin
    idex_d       = '0;
    idex_d.valid = if_valid;
    idex_d.rfa   = rs_val;
    idex_d.rfb   = rt_val;
    idex_d.rfbse = is_r ? rt_val : imm_ext;
    idex_d.shamt = if_inst[10:6];
    idex_d.func  = fn;
    idex_d.waddr = is_r ? rd : (is_jal ? 5'd31 : rt);
    idex_d.jalra = if_pc + XLEN'(JAL_LINK);
    if (if_valid) begin
      idex_d.rfw = !(is_beq || is_bne || is_sw || is_j) && (idex_d.waddr != 5'd0);
      idex_d.drw = is_sw;
      idex_d.wbs = is_lw ? 2'd1 : ((is_jal || is_jalr) ? 2'd2 : 2'd0);
      idex_d.alu = op;
    end
    if (stall || flush) begin
      idex_d.valid = 1'b0;
      idex_d.rfw   = 1'b0;
      idex_d.drw   = 1'b0;
      idex_d.wbs   = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) idex_q <= '0;
    else     idex_q <= idex_d;
  end

  assign p_valid        = idex_q.valid;
  assign p_rfa          = idex_q.rfa;
  assign p_rfb          = idex_q.rfb;
  assign p_rfbse        = idex_q.rfbse;
  assign p_shamt        = idex_q.shamt;
  assign p_func         = idex_q.func;
  assign p_rf_waddr     = idex_q.waddr;
  assign p_jalra        = idex_q.jalra;
  assign p_c_rfw        = idex_q.rfw;
  assign p_c_drw        = idex_q.drw;
  assign p_c_wbsource   = idex_q.wbs;
  assign p_c_alucontrol = idex_q.alu;

endmodule

`default_nettype wire
